dma_desc_dispatcher: RTL and testbench
======================================

// Module: dma_desc_dispatcher
// PURPOSE
//  Descriptor dispatcher between the DMA CSR manager and the read/write DMA engine.
//  Captures each descriptor committed by a host "go" write into a descriptor FIFO.
//  Issues descriptors one at a time to the engine over a valid/ready port, and tracks completion.
//  Reports FIFO and busy status back to the CSR manager, and applies the stop/reset control bits.
// PARAMETERS
//  ADDR_W      64   source/destination byte-address width
//  LEN_W       32   transfer length width (bytes)
//  FIFO_DEPTH  16   descriptor FIFO entries; power of 2, >=2
//  CNT_W       $clog2(FIFO_DEPTH)+1   occupancy counter width (derived, not overridable)
// PORTS
//  clk            in   1       sole clock
//  reset_n        in   1       synchronous, active-low reset
//  csr_go         in   1       1-cycle pulse: push {csr_src_addr,csr_dest_addr,csr_length}
//  csr_src_addr   in   ADDR_W  descriptor source address
//  csr_dest_addr  in   ADDR_W  descriptor destination address
//  csr_length     in   LEN_W   descriptor length in bytes
//  ctl_stop       in   1       level: hold off issuing new descriptors
//  ctl_reset      in   1       level: flush dispatcher (soft reset)
//  desc_valid     out  1       descriptor offered to engine
//  desc_ready     in   1       engine accepts descriptor
//  desc_src_addr  out  ADDR_W  |
//  desc_dest_addr out  ADDR_W  | offered descriptor, stable while desc_valid && !desc_ready
//  desc_length    out  LEN_W   |
//  eng_done       in   1       1-cycle pulse: accepted descriptor finished
//  fifo_full      out  1       occupancy == FIFO_DEPTH
//  fifo_empty     out  1       occupancy == 0
//  desc_count     out  CNT_W   FIFO occupancy, 0..FIFO_DEPTH
//  busy           out  1       state != IDLE || !fifo_empty
//  overflow       out  1       sticky: a go arrived while the FIFO was full
// BEHAVIOUR
//  Reset values: desc_valid=0, desc_* outputs=0, desc_count=0, fifo_empty=1, fifo_full=0, busy=0, overflow=0, state=IDLE.
//  Push: csr_go && !fifo_full writes the entry at the clock edge; desc_count is updated the next cycle.
//    csr_go && fifo_full: entry dropped, overflow<=1.
//  State machine (all transitions registered):
//    IDLE   : !ctl_stop && !ctl_reset && !fifo_empty -> pop head into output regs, desc_valid<=1, ISSUE.
//             No bypass: go at cycle N with empty FIFO -> desc_valid first high at N+2.
//    ISSUE  : desc_valid && desc_ready -> desc_valid<=0, ACTIVE. ctl_stop does not retract a valid offer.
//    ACTIVE : eng_done -> IDLE. A new pop is allowed no earlier than the cycle after eng_done.
//    FLUSH  : entered when ctl_reset=1 from any state.
//      - FIFO is emptied in one cycle, desc_valid<=0, overflow<=0.
//      - Exit to IDLE once ctl_reset=0 and no accepted descriptor is outstanding, i.e.
//        eng_done is seen if entry was from ACTIVE, or if ISSUE had desc_ready in the entry cycle.
//      - csr_go is ignored (not pushed) while in FLUSH.
//  Zero-length descriptor: popped in IDLE, returns straight to IDLE without ever asserting desc_valid.
//  Simultaneous push and pop in one cycle: desc_count unchanged; legal when full (pop frees the slot, so no overflow).
//  eng_done outside ACTIVE/FLUSH-pending: ignored. Pointers wrap modulo FIFO_DEPTH.
//  reset_n low mid-transfer: all state cleared in one cycle; the engine is reset by the same reset_n.
// STRUCTURE
//  dma_pkg:
//    - t_dma_desc struct {src_addr, dest_addr, length}
//    - t_disp_state enum {IDLE, ISSUE, ACTIVE, FLUSH}
//    - DMA_DESCRIPTOR_FIFO_DEPTH constant feeds FIFO_DEPTH.
//  Sub-module dma_desc_fifo: synchronous FIFO of t_dma_desc with push/pop, flush, full/empty, occupancy.
//  The dispatcher FSM and output registers are implemented in this module.
// TESTING
//  1. Single go (src=0x1000, dst=0x2000, len=0x40), desc_ready tied 1 -> desc_valid at go+2 with exact
//     fields; desc_count 1->0; busy high until 1 cycle after eng_done.
//  2. 17 go pulses with FIFO_DEPTH=16, ctl_stop=1 -> fifo_full=1, desc_count=16, overflow=1, desc_valid=0;
//     release stop -> 16 descriptors issued in order, the 17th absent.
//  3. desc_ready low 5 cycles -> desc_valid and fields held stable; no pop; accepted on cycle 6.
//  4. ctl_reset asserted in ACTIVE with 3 queued -> desc_count=0 the next cycle;
//     busy stays 1 until eng_done and ctl_reset=0; overflow cleared.
//  5. FIFO full, go and pop in the same cycle -> desc_count stays 16, overflow stays 0.
//  6. Descriptor with len=0 -> never presented; the following descriptor is issued; desc_count decrements for both.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA descriptor dispatcher.
// Descriptor layout, dispatcher states and default sizing.
package dma_pkg;

  localparam int DMA_ADDR_W = 64;
  localparam int DMA_LEN_W  = 32;
  localparam int DMA_DESCRIPTOR_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src_addr;
    logic [DMA_ADDR_W-1:0] dest_addr;
    logic [DMA_LEN_W-1:0]  length;
  } t_dma_desc;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACTIVE,
    FLUSH
  } t_disp_state;

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with single-cycle flush.
// Push while full is accepted only when a pop frees the slot.
module dma_desc_fifo
  import dma_pkg::*;
#(
  parameter int  DEPTH = DMA_DESCRIPTOR_FIFO_DEPTH,
  parameter type T     = t_dma_desc,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output T              data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/dma_desc_dispatcher.sv
// Descriptor dispatcher: queues CSR "go" descriptors and
// hands them one at a time to the DMA engine.
module dma_desc_dispatcher
  import dma_pkg::*;
#(
  parameter int  ADDR_W     = DMA_ADDR_W,
  parameter int  LEN_W      = DMA_LEN_W,
  parameter int  FIFO_DEPTH = DMA_DESCRIPTOR_FIFO_DEPTH,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              csr_go,
  input  logic [ADDR_W-1:0] csr_src_addr,
  input  logic [ADDR_W-1:0] csr_dest_addr,
  input  logic [LEN_W-1:0]  csr_length,
  input  logic              ctl_stop,
  input  logic              ctl_reset,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [ADDR_W-1:0] desc_src_addr,
  output logic [ADDR_W-1:0] desc_dest_addr,
  output logic [LEN_W-1:0]  desc_length,
  input  logic              eng_done,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [CNT_W-1:0]  desc_count,
  output logic              busy,
  output logic              overflow
);

  typedef struct packed {
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dest_addr;
    logic [LEN_W-1:0]  length;
  } desc_t;

  t_disp_state state_q, state_d;
  desc_t       out_q, out_d;
  desc_t       head;
  desc_t       push_desc;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        pend_q, pend_d;
  logic        push;
  logic        pop;
  logic        flush;

  assign push_desc = '{
    src_addr:  csr_src_addr,
    dest_addr: csr_dest_addr,
    length:    csr_length
  };

  assign push = csr_go && !ctl_reset && (state_q != FLUSH);

  dma_desc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (desc_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (push_desc),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (desc_count)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    pop     = 1'b0;
    flush   = 1'b0;
    if (ctl_reset) begin
      state_d = FLUSH;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      flush   = 1'b1;
      // Remember whether the engine still owes a done.
      unique case (state_q)
        ISSUE:   pend_d = valid_q && desc_ready;
        ACTIVE:  pend_d = !eng_done;
        FLUSH:   pend_d = pend_q && !eng_done;
        default: pend_d = 1'b0;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!ctl_stop && !fifo_empty) begin
            pop = 1'b1;
            if (head.length != '0) begin
              out_d   = head;
              valid_d = 1'b1;
              state_d = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (desc_ready) begin
            valid_d = 1'b0;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (eng_done) state_d = IDLE;
        end
        FLUSH: begin
          if (!pend_q || eng_done) begin
            pend_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (push && fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  assign desc_valid     = valid_q;
  assign desc_src_addr  = out_q.src_addr;
  assign desc_dest_addr = out_q.dest_addr;
  assign desc_length    = out_q.length;
  assign overflow       = ovf_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dma_desc_dispatcher.sv
// Directed bench for dma_desc_dispatcher: cycle table plus
// hand-written overflow, back-pressure, flush and full sequences.
module tb_dma_desc_dispatcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        csr_go;
  logic [63:0] csr_src_addr;
  logic [63:0] csr_dest_addr;
  logic [31:0] csr_length;
  logic        ctl_stop;
  logic        ctl_reset;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_src_addr;
  logic [63:0] desc_dest_addr;
  logic [31:0] desc_length;
  logic        eng_done;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  desc_count;
  logic        busy;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dma_desc_dispatcher dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_go         (csr_go),
    .csr_src_addr   (csr_src_addr),
    .csr_dest_addr  (csr_dest_addr),
    .csr_length     (csr_length),
    .ctl_stop       (ctl_stop),
    .ctl_reset      (ctl_reset),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_src_addr  (desc_src_addr),
    .desc_dest_addr (desc_dest_addr),
    .desc_length    (desc_length),
    .eng_done       (eng_done),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .desc_count     (desc_count),
    .busy           (busy),
    .overflow       (overflow)
  );

  typedef struct {
    logic        go;
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
    logic        stop;
    logic        ready;
    logic        done;
    logic        e_valid;
    logic [63:0] e_src;
    logic [63:0] e_dst;
    logic [31:0] e_len;
    int          e_cnt;
    logic        e_busy;
    logic        e_empty;
  } vec_t;

  vec_t vt [11];

  function automatic vec_t mk(
    input logic go, input logic [63:0] src,
    input logic [63:0] dst, input logic [31:0] len,
    input logic stop, input logic ready, input logic done,
    input logic ev, input logic [63:0] es,
    input logic [63:0] ed, input logic [31:0] el,
    input int ec, input logic eb, input logic ee);
    vec_t v;
    v.go = go; v.src = src; v.dst = dst; v.len = len;
    v.stop = stop; v.ready = ready; v.done = done;
    v.e_valid = ev; v.e_src = es; v.e_dst = ed;
    v.e_len = el; v.e_cnt = ec; v.e_busy = eb;
    v.e_empty = ee;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h",
                  nm, act, exp);
  endtask

  task automatic set_go(input logic [63:0] s,
                        input logic [63:0] d,
                        input logic [31:0] l);
    csr_go        = 1'b1;
    csr_src_addr  = s;
    csr_dest_addr = d;
    csr_length    = l;
  endtask

  int n;

  initial begin
    reset_n = 1'b0;
    csr_go = 1'b0; csr_src_addr = '0;
    csr_dest_addr = '0; csr_length = '0;
    ctl_stop = 1'b0; ctl_reset = 1'b0;
    desc_ready = 1'b0; eng_done = 1'b0;

    // single go (rows 0-4) and zero-length skip (rows 5-10)
    vt[0]  = mk(1, 64'h1000, 64'h2000, 32'h40, 0, 1, 0,
                0, 0, 0, 0, 1, 1, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 1, 0,
                1, 64'h1000, 64'h2000, 32'h40, 0, 1, 1);
    vt[2]  = mk(0, 0, 0, 0, 0, 1, 0,
                0, 0, 0, 0, 0, 1, 1);
    vt[3]  = mk(0, 0, 0, 0, 0, 1, 0,
                0, 0, 0, 0, 0, 1, 1);
    vt[4]  = mk(0, 0, 0, 0, 0, 1, 1,
                0, 0, 0, 0, 0, 0, 1);
    vt[5]  = mk(1, 64'h3000, 64'h4000, 32'h0, 1, 1, 0,
                0, 0, 0, 0, 1, 1, 0);
    vt[6]  = mk(1, 64'h5000, 64'h6000, 32'h80, 1, 1, 0,
                0, 0, 0, 0, 2, 1, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 1, 0,
                0, 0, 0, 0, 1, 1, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 1, 0,
                1, 64'h5000, 64'h6000, 32'h80, 0, 1, 1);
    vt[9]  = mk(0, 0, 0, 0, 0, 1, 0,
                0, 0, 0, 0, 0, 1, 1);
    vt[10] = mk(0, 0, 0, 0, 0, 1, 1,
                0, 0, 0, 0, 0, 0, 1);

    step(); step();
    chk("rst_valid", desc_valid, 0);
    chk("rst_src", desc_src_addr, 0);
    chk("rst_len", desc_length, 0);
    chk("rst_count", desc_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      csr_go        = vt[i].go;
      csr_src_addr  = vt[i].src;
      csr_dest_addr = vt[i].dst;
      csr_length    = vt[i].len;
      ctl_stop      = vt[i].stop;
      desc_ready    = vt[i].ready;
      eng_done      = vt[i].done;
      step();
      chk($sformatf("vec%0d_valid", i), desc_valid, vt[i].e_valid);
      chk($sformatf("vec%0d_count", i), desc_count,
          64'(vt[i].e_cnt));
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_empty", i), fifo_empty, vt[i].e_empty);
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_src", i), desc_src_addr, vt[i].e_src);
        chk($sformatf("vec%0d_dst", i), desc_dest_addr, vt[i].e_dst);
        chk($sformatf("vec%0d_len", i), desc_length, vt[i].e_len);
      end
    end
    csr_go = 1'b0;
    eng_done = 1'b0;

    // 17 pushes while stopped: last one overflows
    ctl_stop = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_go(64'h100 * (i + 1), 64'h8000_0000 + 64'(i),
             32'(16 * (i + 1)));
      step();
    end
    csr_go = 1'b0;
    chk("ovf_full", fifo_full, 1);
    chk("ovf_count", desc_count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_valid", desc_valid, 0);
    ctl_stop = 1'b0;
    desc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (!desc_valid && n < 10) begin
        step();
        n++;
      end
      if (!desc_valid) begin
        chk("drain_timeout", 0, 1);
        break;
      end
      chk($sformatf("drain%0d_src", i), desc_src_addr,
          64'h100 * (i + 1));
      chk($sformatf("drain%0d_len", i), desc_length,
          64'(16 * (i + 1)));
      step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
    end
    repeat (4) step();
    chk("drain_no17_valid", desc_valid, 0);
    chk("drain_empty", fifo_empty, 1);
    chk("drain_idle", busy, 0);

    // back-pressure: offer held for 5 cycles
    desc_ready = 1'b0;
    set_go(64'hA0A0, 64'hB0B0, 32'h10);
    step();
    set_go(64'hC0C0, 64'hD0D0, 32'h20);
    step();
    csr_go = 1'b0;
    chk("bp_valid", desc_valid, 1);
    chk("bp_count", desc_count, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d_valid", i), desc_valid, 1);
      chk($sformatf("bp%0d_src", i), desc_src_addr, 64'hA0A0);
      chk($sformatf("bp%0d_dst", i), desc_dest_addr, 64'hB0B0);
      chk($sformatf("bp%0d_count", i), desc_count, 1);
    end
    desc_ready = 1'b1;
    step();
    chk("bp_accept_valid", desc_valid, 0);
    chk("bp_accept_count", desc_count, 1);

    // soft reset while ACTIVE with three queued
    set_go(64'hE0E0, 64'hE1E1, 32'h30);
    step();
    set_go(64'hF0F0, 64'hF1F1, 32'h40);
    step();
    csr_go = 1'b0;
    chk("fl_pre_count", desc_count, 3);
    chk("fl_pre_ovf", overflow, 1);
    ctl_reset = 1'b1;
    step();
    chk("fl_count", desc_count, 0);
    chk("fl_ovf", overflow, 0);
    chk("fl_valid", desc_valid, 0);
    chk("fl_busy0", busy, 1);
    set_go(64'h7777, 64'h7777, 32'h7);
    step();
    csr_go = 1'b0;
    step();
    chk("fl_busy1", busy, 1);
    chk("fl_go_ignored", desc_count, 0);
    ctl_reset = 1'b0;
    step();
    chk("fl_busy_pend", busy, 1);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("fl_busy_done", busy, 0);
    chk("fl_end_empty", fifo_empty, 1);

    // full FIFO: push and pop in the same cycle
    ctl_stop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_go(64'h2000 + 64'(i), 64'h3000, 32'h8);
      step();
    end
    csr_go = 1'b0;
    chk("sp_pre_full", fifo_full, 1);
    chk("sp_pre_ovf", overflow, 0);
    ctl_stop = 1'b0;
    desc_ready = 1'b0;
    set_go(64'h9999, 64'h9999, 32'h8);
    step();
    csr_go = 1'b0;
    chk("sp_count", desc_count, 16);
    chk("sp_ovf", overflow, 0);
    chk("sp_full", fifo_full, 1);
    chk("sp_valid", desc_valid, 1);
    chk("sp_src", desc_src_addr, 64'h2000);

    // hard reset mid-transfer
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("hr_valid", desc_valid, 0);
    chk("hr_count", desc_count, 0);
    chk("hr_empty", fifo_empty, 1);
    chk("hr_busy", busy, 0);
    chk("hr_src", desc_src_addr, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
